// File: rtl/pcs_pkg.sv
// Shared definitions for the PCS code-group synchronizer: state codes,
// comma bit patterns and the running-disparity popcount window.
package pcs_pkg;

  // Synchronization states; the numeric codes appear on the sync_state port.
  typedef enum logic [2:0] {
    LOSS_OF_SYNC  = 3'd0,
    COMMA_DETECT  = 3'd1,
    SYNC_ACQUIRED = 3'd2,
    SYNC_BAD      = 3'd3
  } sync_state_e;

  // Seven leading bits (a..g) of a comma in either disparity.
  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;

  // A legal 10-bit code group carries between four and six ones.
  localparam logic [3:0] POP_MIN = 4'd4;
  localparam logic [3:0] POP_MAX = 4'd6;

  // Number of ones in a 10-bit code group.
  function automatic logic [3:0] popcount10(input logic [9:0] cg);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 10; i++) begin
      cnt = cnt + {3'b000, cg[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pcs_cg_check.sv
// Purely combinational classification of one received code group:
// whether it starts with a comma and whether its ones count is legal.
module pcs_cg_check
  import pcs_pkg::*;
(
  input  logic [9:0] rx_code_group,
  output logic       is_comma,
  output logic       is_valid_disp
);

  logic [3:0] ones;

  // Classify the code group from its leading bits and its ones count.
  always_comb begin
    ones          = popcount10(rx_code_group);
    is_comma      = (rx_code_group[9:3] == COMMA_POS) ||
                    (rx_code_group[9:3] == COMMA_NEG);
    is_valid_disp = (ones >= POP_MIN) && (ones <= POP_MAX);
  end

endmodule

// File: rtl/pcs_sync_param.sv
// Parameterized code-group synchronizer: aligns on even commas, tracks
// code-group quality while in sync and counts loss-of-sync events.
module pcs_sync_param
  import pcs_pkg::*;
#(
  parameter int ACQ_COMMAS = 3,
  parameter int GOOD_CGS   = 4,
  parameter int LOSS_BADS  = 4,
  parameter int LOSS_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  signal_detect,
  input  logic [9:0]            rx_code_group,
  output logic [9:0]            rx_code_group_out,
  output logic                  code_status,
  output logic                  rx_even,
  output logic [2:0]            sync_state,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int CW = $clog2(ACQ_COMMAS + 1);
  localparam int GW = $clog2(GOOD_CGS + 1);
  localparam int BW = $clog2(LOSS_BADS + 1);

  localparam logic [CW-1:0] COMMA_ONE  = CW'(1);
  localparam logic [CW-1:0] COMMA_GOAL = CW'(ACQ_COMMAS);
  localparam logic [GW-1:0] GOOD_GOAL  = GW'(GOOD_CGS);
  localparam logic [BW-1:0] BAD_ONE    = BW'(1);
  localparam logic [BW-1:0] BAD_GOAL   = BW'(LOSS_BADS);

  sync_state_e           state_q, state_d;
  logic [CW-1:0]         comma_cnt_q, comma_cnt_d;
  logic [GW-1:0]         good_cnt_q, good_cnt_d;
  logic [BW-1:0]         bad_cnt_q, bad_cnt_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  rx_even_q, rx_even_d;
  logic                  code_status_q, code_status_d;
  logic [9:0]            rx_cg_out_q, rx_cg_out_d;

  logic is_comma;
  logic is_valid_disp;
  logic cg_invalid;
  logic loss_event;

  pcs_cg_check u_cg_check (
    .rx_code_group (rx_code_group),
    .is_comma      (is_comma),
    .is_valid_disp (is_valid_disp)
  );

  // State register and all registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q       <= LOSS_OF_SYNC;
      comma_cnt_q   <= '0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      loss_cnt_q    <= '0;
      rx_even_q     <= 1'b1;
      code_status_q <= 1'b0;
      rx_cg_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      comma_cnt_q   <= comma_cnt_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      loss_cnt_q    <= loss_cnt_d;
      rx_even_q     <= rx_even_d;
      code_status_q <= code_status_d;
      rx_cg_out_q   <= rx_cg_out_d;
    end
  end

  // Next state and counters; losing signal_detect overrides everything.
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    loss_event  = 1'b0;
    cg_invalid  = !is_valid_disp || (is_comma && !rx_even_q);

    if (!signal_detect) begin
      state_d     = LOSS_OF_SYNC;
      comma_cnt_d = '0;
      good_cnt_d  = '0;
      bad_cnt_d   = '0;
      loss_event  = (state_q == SYNC_ACQUIRED) || (state_q == SYNC_BAD);
    end else begin
      case (state_q)
        LOSS_OF_SYNC: begin
          if (is_comma) begin
            if (ACQ_COMMAS <= 1) begin
              state_d     = SYNC_ACQUIRED;
              comma_cnt_d = '0;
            end else begin
              state_d     = COMMA_DETECT;
              comma_cnt_d = COMMA_ONE;
            end
          end
        end
        COMMA_DETECT: begin
          if (cg_invalid) begin
            state_d     = LOSS_OF_SYNC;
            comma_cnt_d = '0;
          end else if (is_comma) begin
            if (comma_cnt_q + 1'b1 == COMMA_GOAL) begin
              state_d     = SYNC_ACQUIRED;
              comma_cnt_d = '0;
            end else begin
              comma_cnt_d = comma_cnt_q + 1'b1;
            end
          end
        end
        SYNC_ACQUIRED: begin
          if (cg_invalid) begin
            good_cnt_d = '0;
            if (LOSS_BADS <= 1) begin
              state_d    = LOSS_OF_SYNC;
              bad_cnt_d  = '0;
              loss_event = 1'b1;
            end else begin
              state_d   = SYNC_BAD;
              bad_cnt_d = BAD_ONE;
            end
          end
        end
        SYNC_BAD: begin
          if (cg_invalid) begin
            good_cnt_d = '0;
            if (bad_cnt_q + 1'b1 == BAD_GOAL) begin
              state_d    = LOSS_OF_SYNC;
              bad_cnt_d  = '0;
              loss_event = 1'b1;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end else if (good_cnt_q + 1'b1 == GOOD_GOAL) begin
            good_cnt_d = '0;
            bad_cnt_d  = bad_cnt_q - 1'b1;
            if (bad_cnt_q == BAD_ONE) begin
              state_d = SYNC_ACQUIRED;
            end
          end else begin
            good_cnt_d = good_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d     = LOSS_OF_SYNC;
          comma_cnt_d = '0;
          good_cnt_d  = '0;
          bad_cnt_d   = '0;
        end
      endcase
    end

    if (loss_event && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  // Values presented one clock later: status, parity and the code group.
  always_comb begin
    code_status_d = (state_d == SYNC_ACQUIRED) || (state_d == SYNC_BAD);
    rx_even_d     = is_comma ? 1'b0 : !rx_even_q;
    rx_cg_out_d   = rx_code_group;
  end

  assign sync_state        = state_q;
  assign code_status       = code_status_q;
  assign rx_even           = rx_even_q;
  assign rx_code_group_out = rx_cg_out_q;
  assign loss_cnt          = loss_cnt_q;

endmodule

// File: tb/tb_pcs_sync_param.sv
// Self-checking bench for pcs_sync_param: one default instance and one with
// single-comma acquisition and a 2-bit loss counter, driven by the same
// stream and compared every cycle against a behavioural model of each.
module tb_pcs_sync_param;

  localparam logic [9:0] K285P   = 10'b0011111010;
  localparam logic [9:0] K285N   = 10'b1100000101;
  localparam logic [9:0] DATA    = 10'b1001110100;
  localparam logic [9:0] BAD_POP = 10'b1111111000;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       signal_detect = 1'b1;
  logic [9:0] rx_code_group = '0;

  logic [9:0] a_cg_out, b_cg_out;
  logic       a_status, b_status;
  logic       a_even, b_even;
  logic [2:0] a_state, b_state;
  logic [7:0] a_loss;
  logic [1:0] b_loss;

  int checks   = 0;
  int failures = 0;

  // A compact description of what the synchronizer should be doing,
  // kept as plain integers so it can be reasoned about independently.
  typedef struct {
    int         st;
    int         commas;
    int         good;
    int         bad;
    int         losses;
    bit         even;
    logic [9:0] cgOut;
    int         acq;
    int         goodN;
    int         lossN;
    int         lossMax;
  } model_t;

  model_t ma, mb;

  logic [9:0] dataTab [4];

  // Free-running 100 MHz style clock.
  always #5 clk = ~clk;

  pcs_sync_param dut_a (
    .clk               (clk),
    .RESET             (RESET),
    .signal_detect     (signal_detect),
    .rx_code_group     (rx_code_group),
    .rx_code_group_out (a_cg_out),
    .code_status       (a_status),
    .rx_even           (a_even),
    .sync_state        (a_state),
    .loss_cnt          (a_loss)
  );

  pcs_sync_param #(
    .ACQ_COMMAS (1),
    .LOSS_CNT_W (2)
  ) dut_b (
    .clk               (clk),
    .RESET             (RESET),
    .signal_detect     (signal_detect),
    .rx_code_group     (rx_code_group),
    .rx_code_group_out (b_cg_out),
    .code_status       (b_status),
    .rx_even           (b_even),
    .sync_state        (b_state),
    .loss_cnt          (b_loss)
  );

  // Every comparison funnels through here so counts stay consistent.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Put a model back into its post-reset condition.
  function automatic model_t modelReset(input model_t m);
    model_t r;
    r        = m;
    r.st     = 0;
    r.commas = 0;
    r.good   = 0;
    r.bad    = 0;
    r.losses = 0;
    r.even   = 1'b1;
    r.cgOut  = '0;
    return r;
  endfunction

  // Advance a model by one received code group following the sync rules.
  function automatic model_t modelStep(input model_t m, input bit sd, input logic [9:0] cg);
    model_t r;
    bit     comma;
    bit     invalid;
    bit     wasSync;
    int     ones;
    r       = m;
    ones    = $countones(cg);
    comma   = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    invalid = (ones < 4) || (ones > 6) || (comma && !m.even);
    wasSync = (m.st == 2) || (m.st == 3);
    if (!sd) begin
      r.st = 0; r.commas = 0; r.good = 0; r.bad = 0;
      if (wasSync) r.losses++;
    end else if (m.st == 0) begin
      if (comma) begin
        r.commas = 1;
        r.st     = 1;
        if (r.commas >= m.acq) begin r.st = 2; r.commas = 0; end
      end
    end else if (m.st == 1) begin
      if (invalid) begin
        r.st = 0; r.commas = 0;
      end else if (comma) begin
        r.commas++;
        if (r.commas >= m.acq) begin r.st = 2; r.commas = 0; end
      end
    end else if (m.st == 2) begin
      if (invalid) begin
        r.st = 3; r.bad = 1; r.good = 0;
        if (r.bad >= m.lossN) begin r.st = 0; r.bad = 0; r.losses++; end
      end
    end else begin
      if (invalid) begin
        r.bad++; r.good = 0;
        if (r.bad >= m.lossN) begin r.st = 0; r.bad = 0; r.losses++; end
      end else begin
        r.good++;
        if (r.good >= m.goodN) begin
          r.good = 0;
          r.bad--;
          if (r.bad == 0) r.st = 2;
        end
      end
    end
    r.even  = comma ? 1'b0 : !m.even;
    r.cgOut = cg;
    return r;
  endfunction

  // Compare both instances against their models.
  task automatic compareAll();
    checkOutput("a_state",  int'(a_state),  ma.st);
    checkOutput("a_status", int'(a_status), (ma.st >= 2) ? 1 : 0);
    checkOutput("a_even",   int'(a_even),   int'(ma.even));
    checkOutput("a_cg_out", int'(a_cg_out), int'(ma.cgOut));
    checkOutput("a_loss",   int'(a_loss),   (ma.losses > ma.lossMax) ? ma.lossMax : ma.losses);
    checkOutput("b_state",  int'(b_state),  mb.st);
    checkOutput("b_status", int'(b_status), (mb.st >= 2) ? 1 : 0);
    checkOutput("b_even",   int'(b_even),   int'(mb.even));
    checkOutput("b_cg_out", int'(b_cg_out), int'(mb.cgOut));
    checkOutput("b_loss",   int'(b_loss),   (mb.losses > mb.lossMax) ? mb.lossMax : mb.losses);
  endtask

  // Drive one cycle of input on the falling edge, let the rising edge
  // register it, advance the models and check just after the edge.
  task automatic applyStimulus(input bit rst, input bit sd, input logic [9:0] cg);
    @(negedge clk);
    RESET         = rst;
    signal_detect = sd;
    rx_code_group = cg;
    @(posedge clk);
    if (rst) begin
      ma = modelReset(ma);
      mb = modelReset(mb);
    end else begin
      ma = modelStep(ma, sd, cg);
      mb = modelStep(mb, sd, cg);
    end
    #1;
    compareAll();
  endtask

  // Comma/data pairs ending on a comma: three even commas reach sync.
  task automatic acquireSync();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, K285P);
      if (i < 2) applyStimulus(1'b0, 1'b1, DATA);
    end
  endtask

  // Directed scenarios first, then a long randomized stream.
  initial begin
    logic [9:0] cg;
    bit         rst;
    bit         sd;
    bit         dataSlot;

    dataTab[0] = 10'b1001110100;
    dataTab[1] = 10'b0101010101;
    dataTab[2] = 10'b1010101010;
    dataTab[3] = 10'b0110011010;

    ma.acq = 3; ma.goodN = 4; ma.lossN = 4; ma.lossMax = 255;
    mb.acq = 1; mb.goodN = 4; mb.lossN = 4; mb.lossMax = 3;
    ma = modelReset(ma);
    mb = modelReset(mb);

    $display("[TB] reset and initial state");
    applyStimulus(1'b1, 1'b1, DATA);
    applyStimulus(1'b1, 1'b1, DATA);
    checkOutput("rst_state",  int'(a_state),  0);
    checkOutput("rst_status", int'(a_status), 0);
    checkOutput("rst_even",   int'(a_even),   1);
    checkOutput("rst_loss",   int'(a_loss),   0);

    $display("[TB] acquisition with three even commas");
    acquireSync();
    checkOutput("acq_status", int'(a_status), 1);
    checkOutput("acq_state",  int'(a_state),  2);
    checkOutput("acq1_state", int'(b_state),  2);
    applyStimulus(1'b0, 1'b1, DATA);

    $display("[TB] one bad code group recovered by four good ones");
    applyStimulus(1'b0, 1'b1, BAD_POP);
    checkOutput("bad_state",  int'(a_state),  3);
    checkOutput("bad_status", int'(a_status), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, DATA);
      checkOutput("recover_state",  int'(a_state),  (i < 3) ? 3 : 2);
      checkOutput("recover_status", int'(a_status), 1);
    end

    $display("[TB] four bad code groups lose sync");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, BAD_POP);
    checkOutput("lost_state",  int'(a_state),  0);
    checkOutput("lost_status", int'(a_status), 0);
    checkOutput("lost_loss",   int'(a_loss),   1);

    $display("[TB] odd comma while detecting commas");
    applyStimulus(1'b0, 1'b1, K285P);
    checkOutput("cd_state", int'(a_state), 1);
    applyStimulus(1'b0, 1'b1, K285N);
    checkOutput("odd_comma_state", int'(a_state), 0);

    $display("[TB] signal_detect drop in SYNC_BAD with a valid code group");
    applyStimulus(1'b0, 1'b1, DATA);
    acquireSync();
    applyStimulus(1'b0, 1'b1, BAD_POP);
    checkOutput("sb_state", int'(a_state), 3);
    applyStimulus(1'b0, 1'b0, DATA);
    checkOutput("sd_state", int'(a_state), 0);
    checkOutput("sd_loss",  int'(a_loss),  2);

    $display("[TB] repeated losses saturate the narrow counter");
    for (int i = 0; i < 5; i++) begin
      acquireSync();
      applyStimulus(1'b0, 1'b0, DATA);
    end
    checkOutput("sat_loss_b", int'(b_loss), 3);
    checkOutput("sat_loss_a", int'(a_loss), 7);

    $display("[TB] reset in sync clears loss count, dominates signal_detect");
    acquireSync();
    applyStimulus(1'b1, 1'b0, DATA);
    checkOutput("mid_rst_loss",  int'(a_loss),  0);
    checkOutput("mid_rst_state", int'(a_state), 0);
    checkOutput("mid_rst_even",  int'(a_even),  1);

    $display("[TB] randomized stream");
    dataSlot = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      sd  = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 99) < 6) begin
        cg = 10'($urandom);
      end else if (!dataSlot && ($urandom_range(0, 9) < 6)) begin
        cg = ($urandom_range(0, 1) == 0) ? K285P : K285N;
      end else begin
        cg = dataTab[$urandom_range(0, 3)];
      end
      if ((cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000)) dataSlot = 1'b1;
      else dataSlot = !dataSlot;
      applyStimulus(rst, sd, cg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcs_sync_param.md
PCS_SYNC_PARAM -- requirements
Module: pcs_sync_param

Interface
REQ-001 Parameter ACQ_COMMAS, default 3: number of even-aligned commas required to declare sync.
REQ-002 Parameter GOOD_CGS, default 4: consecutive valid code groups that retire one bad count.
REQ-003 Parameter LOSS_BADS, default 4: bad count at which sync is lost.
REQ-004 Parameter LOSS_CNT_W, default 8: width of the loss-event counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 signal_detect  in  1  PMA signal present; low forces loss of sync.
REQ-008 rx_code_group  in  10  received code group, bit 9 = first bit on the line ("a").
REQ-009 rx_code_group_out  out  10  rx_code_group delayed by one clk.
REQ-010 code_status  out  1  1 while in SYNC_ACQUIRED or SYNC_BAD.
REQ-011 rx_even  out  1  1 when the current output code group occupies an even position.
REQ-012 sync_state  out  3  current FSM state encoding.
REQ-013 loss_cnt  out  LOSS_CNT_W  saturating count of SYNC->LOSS_OF_SYNC transitions.

Function
REQ-014 Comma: rx_code_group[9:3] equals 0011111 or 1100000.
REQ-015 Invalid: popcount(rx_code_group) not in {4,5,6}, or comma while rx_even is 0 (odd-position comma).
REQ-016 rx_even toggles every clk; a comma forces next rx_even to 0 (comma itself counted even).
REQ-017 States: LOSS_OF_SYNC, COMMA_DETECT, SYNC_ACQUIRED, SYNC_BAD; codes 0,1,2,3.
REQ-018 LOSS_OF_SYNC: comma -> COMMA_DETECT, comma_cnt=1; otherwise stay.
REQ-019 COMMA_DETECT: invalid -> LOSS_OF_SYNC, comma_cnt=0; even comma -> comma_cnt+1; comma_cnt reaching ACQ_COMMAS -> SYNC_ACQUIRED.
REQ-020 ACQ_COMMAS=1: first comma in LOSS_OF_SYNC goes directly to SYNC_ACQUIRED.
REQ-021 SYNC_ACQUIRED: invalid -> SYNC_BAD, bad_cnt=1, good_cnt=0; valid -> stay.
REQ-022 SYNC_BAD: invalid -> bad_cnt+1, good_cnt=0; valid -> good_cnt+1.
REQ-023 SYNC_BAD: good_cnt reaching GOOD_CGS -> bad_cnt-1, good_cnt=0; bad_cnt reaching 0 -> SYNC_ACQUIRED.
REQ-024 SYNC_BAD: bad_cnt reaching LOSS_BADS -> LOSS_OF_SYNC, all counters cleared, loss_cnt+1.
REQ-025 signal_detect=0 -> LOSS_OF_SYNC next clk from any state, dominating all other events; loss_cnt+1 only if leaving SYNC_ACQUIRED/SYNC_BAD.
REQ-026 loss_cnt saturates at all-ones; no wrap.
REQ-027 code_status, sync_state, rx_even, rx_code_group_out all registered; latency 1 clk from input to corresponding output.
REQ-028 Counter widths: $clog2(param+1) each; no overflow possible by construction.

Reset
REQ-029 RESET=1 at a clk edge: state LOSS_OF_SYNC, code_status=0, rx_even=1, rx_code_group_out=0, loss_cnt=0, all internal counters 0.
REQ-030 RESET mid-sync clears loss_cnt and does not count as a loss event; RESET dominates signal_detect.

Structure
REQ-031 Shared package pcs_pkg holds state encodings, the two comma 7-bit patterns, and the popcount bounds.
REQ-032 Sub-module pcs_cg_check (combinational): outputs is_comma, is_valid_disp from rx_code_group; FSM and counters stay in pcs_sync_param.
REQ-033 pcs_sync_param is a drop-in for the existing synchronizer at default parameters.

Verification
REQ-034 Reset, signal_detect=1, three K28.5 (0011111010) each followed by 1 data cg (e.g. 1001110100) -> code_status=1 one clk after the third comma.
REQ-035 In sync, one cg 1111111000 (popcount 7) then 4 valid cgs -> sync_state 3 then back to 2 after 4th valid; code_status stays 1.
REQ-036 In sync, 4 invalid cgs back-to-back -> sync_state 0, code_status=0, loss_cnt=1.
REQ-037 In COMMA_DETECT, comma on odd position -> LOSS_OF_SYNC, comma_cnt 0.
REQ-038 signal_detect dropped for 1 clk while in SYNC_BAD coinciding with a valid cg -> LOSS_OF_SYNC next clk, loss_cnt+1.
REQ-039 LOSS_CNT_W=2, force 5 loss events -> loss_cnt holds 3.
